// File: rtl/resolution_fetch_ctrl_pkg.sv
// Shared video-mode types and ROM geometry for the resolution-text fetch path.
package resolution_fetch_ctrl_pkg;

   localparam int RESLINE_SIZE = 32;

   localparam logic [3:0] MODE_VGA     = 4'd0;
   localparam logic [3:0] MODE_480p60  = 4'd1;
   localparam logic [3:0] MODE_720p60  = 4'd2;
   localparam logic [3:0] MODE_1080p60 = 4'd3;

   typedef struct packed {
      logic [3:0]  id;
      logic [11:0] h_active;
      logic [10:0] v_active;
      logic [7:0]  refresh_hz;
   } VideoMode;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      FETCH  = 2'd2,
      SWAP   = 2'd3
   } ResFetchState;

endpackage

// File: rtl/resline_bank.sv
// Two banks of resolution-text lines: one written by the fetch sweep, one read by the OSD.
module resline_bank
   import resolution_fetch_ctrl_pkg::*;
#(
   parameter int LINES = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    wr_bank,
   input  logic [3:0]              wr_addr,
   input  logic [RESLINE_SIZE-1:0] wr_data,
   input  logic                    wr_en,
   input  logic                    rd_bank,
   input  logic [3:0]              rd_addr,
   output logic [RESLINE_SIZE-1:0] rd_data
);

   logic [RESLINE_SIZE-1:0] mem_q [0:1][0:LINES-1];
   logic [RESLINE_SIZE-1:0] rd_data_q;

   // line storage, cleared on reset so an unswapped label reads as blank
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < LINES; l++) begin
               mem_q[b][l] <= '0;
            end
         end
      end else if (wr_en) begin
         mem_q[wr_bank][wr_addr] <= wr_data;
      end
   end

   // registered read port
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[rd_bank][rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/resolution_fetch_ctrl.sv
// Waits for the video mode to settle, sweeps the mode's ROM lines into a shadow bank,
// then swaps that bank in so the OSD never sees a half-updated label.
module resolution_fetch_ctrl
   import resolution_fetch_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int LINES         = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  VideoMode                videoMode,
   input  logic                    refresh,
   output VideoMode                rom_mode,
   output logic [3:0]              rom_addr,
   input  logic [RESLINE_SIZE-1:0] rom_q,
   input  logic [3:0]              rd_addr,
   output logic [RESLINE_SIZE-1:0] rd_data,
   output logic                    label_valid,
   output logic                    busy,
   output logic                    done
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [3:0]       LAST_ADDR  = 4'(LINES - 1);

   ResFetchState     state_q, state_d;
   logic [3:0]       mode_id_q;
   logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
   VideoMode         rom_mode_q, rom_mode_d;
   logic [3:0]       rom_addr_q, rom_addr_d;
   logic             hold_q, hold_d;
   logic             issued_q, issued_d;
   logic [3:0]       wr_addr_q;
   logic             active_q, active_d;
   logic             label_valid_q, label_valid_d;
   logic             busy_q, done_q;
   logic             change_s;
   logic             wr_en_s;

   assign change_s = (videoMode.id != mode_id_q);

   // next-state: settle, sweep with trailing capture, swap
   always_comb begin
      state_d       = state_q;
      settle_cnt_d  = settle_cnt_q;
      rom_mode_d    = rom_mode_q;
      rom_addr_d    = rom_addr_q;
      hold_d        = hold_q;
      issued_d      = 1'b0;
      active_d      = active_q;
      label_valid_d = label_valid_q;
      wr_en_s       = 1'b0;
      case (state_q)
         IDLE: begin
            if (change_s || refresh) begin
               state_d      = SETTLE;
               settle_cnt_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         SETTLE: begin
            if (change_s) begin
               settle_cnt_d = '0;
            end else if (settle_cnt_q == SETTLE_MAX) begin
               state_d    = FETCH;
               rom_mode_d = videoMode;
               rom_addr_d = 4'd0;
               hold_d     = 1'b0;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         FETCH: begin
            if (change_s) begin
               state_d      = SETTLE;
               settle_cnt_d = '0;
               hold_d       = 1'b0;
            end else if (hold_q) begin
               wr_en_s = issued_q;
               state_d = SWAP;
               hold_d  = 1'b0;
            end else begin
               wr_en_s  = issued_q;
               issued_d = 1'b1;
               if (rom_addr_q == LAST_ADDR) begin
                  hold_d = 1'b1;
               end else begin
                  rom_addr_d = rom_addr_q + 4'd1;
               end
            end
         end
         SWAP: begin
            active_d      = ~active_q;
            label_valid_d = 1'b1;
            settle_cnt_d  = '0;
            // a mode change seen during the swap must not be lost
            state_d       = change_s ? SETTLE : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // controller registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         mode_id_q     <= 4'hF;
         settle_cnt_q  <= '0;
         rom_mode_q    <= '0;
         rom_addr_q    <= 4'd0;
         hold_q        <= 1'b0;
         issued_q      <= 1'b0;
         wr_addr_q     <= 4'd0;
         active_q      <= 1'b0;
         label_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_id_q     <= videoMode.id;
         settle_cnt_q  <= settle_cnt_d;
         rom_mode_q    <= rom_mode_d;
         rom_addr_q    <= rom_addr_d;
         hold_q        <= hold_d;
         issued_q      <= issued_d;
         wr_addr_q     <= rom_addr_q;
         active_q      <= active_d;
         label_valid_q <= label_valid_d;
         busy_q        <= (state_d != IDLE);
         done_q        <= (state_q == SWAP);
      end
   end

   resline_bank #(.LINES(LINES)) u_bank (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_bank (~active_q),
      .wr_addr (wr_addr_q),
      .wr_data (rom_q),
      .wr_en   (wr_en_s),
      .rd_bank (active_q),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign rom_mode    = rom_mode_q;
   assign rom_addr    = rom_addr_q;
   assign label_valid = label_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_resolution_fetch_ctrl.sv
// Scoreboard bench for resolution_fetch_ctrl with a registered ROM model.
module tb_resolution_fetch_ctrl;
   import resolution_fetch_ctrl_pkg::*;

   logic                    clock;
   logic                    reset_n;
   VideoMode                videoMode;
   logic                    refresh;
   VideoMode                rom_mode;
   logic [3:0]              rom_addr;
   logic [RESLINE_SIZE-1:0] rom_q;
   logic [3:0]              rd_addr;
   logic [RESLINE_SIZE-1:0] rd_data;
   logic                    label_valid;
   logic                    busy;
   logic                    done;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   logic [RESLINE_SIZE-1:0] rd_q [$];
   logic       rd_en_tb = 1'b0;
   logic       rd_chk   = 1'b0;
   logic [3:0] act_id      = 4'd0;
   bit         act_valid   = 1'b0;
   logic [3:0] last_rom_id = 4'd0;

   resolution_fetch_ctrl #(.SETTLE_CYCLES(4), .LINES(16)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .videoMode   (videoMode),
      .refresh     (refresh),
      .rom_mode    (rom_mode),
      .rom_addr    (rom_addr),
      .rom_q       (rom_q),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .label_valid (label_valid),
      .busy        (busy),
      .done        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [RESLINE_SIZE-1:0] rom_line(input logic [3:0] id, input logic [3:0] a);
      logic [7:0] ia;
      ia = {id, a};
      return {ia, ~{a, id}, 8'hC3 ^ {a, id}, ia ^ 8'h5A};
   endfunction

   function automatic logic [RESLINE_SIZE-1:0] exp_line(input bit v, input logic [3:0] id, input logic [3:0] a);
      return v ? rom_line(id, a) : '0;
   endfunction

   function automatic VideoMode make_mode(input logic [3:0] id);
      VideoMode m;
      m.id         = id;
      m.h_active   = 12'd640 + 12'(id) * 12'd100;
      m.v_active   = 11'd480 + 11'(id) * 11'd60;
      m.refresh_hz = 8'd60;
      return m;
   endfunction

   // ROM model: data for the presented address one cycle later
   always @(posedge clock) rom_q <= rom_line(rom_mode.id, rom_addr);

   always @(posedge clock) rd_chk <= rd_en_tb;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // read scoreboard and done counter
   always @(negedge clock) begin
      if (done) done_cnt++;
      if (rd_chk) begin
         if (rd_q.size() == 0) check_eq("rd_unexpected", 64'd1, 64'd0);
         else check_eq("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
      end
   end

   task automatic issue_read(input logic [3:0] a, input logic [RESLINE_SIZE-1:0] exp);
      rd_addr  = a;
      rd_en_tb = 1'b1;
      rd_q.push_back(exp);
   endtask

   task automatic read_all();
      for (int a = 0; a < 16; a++) begin
         @(negedge clock);
         issue_read(4'(a), exp_line(act_valid, act_id, 4'(a)));
      end
      @(negedge clock);
      rd_en_tb = 1'b0;
      @(negedge clock);
   endtask

   // Follows one settle/fetch/swap from a change driven at the current negedge.
   // done is high after edge 23, i.e. captured downstream at edge 24.
   task automatic follow_fetch(input logic [3:0] new_id, input bit mid_refresh);
      for (int k = 1; k <= 23; k++) begin
         @(negedge clock);
         rd_en_tb = 1'b0;
         refresh  = (mid_refresh && k == 10);
         if (k <= 16) issue_read(4'(k - 1), exp_line(act_valid, act_id, 4'(k - 1)));
         if (k == 4) check_eq("mode_held_settle", 64'(rom_mode.id), 64'(last_rom_id));
         if (k >= 5 && k <= 20) check_eq("sweep_addr", 64'(rom_addr), 64'(k - 5));
         if (k == 21) check_eq("capture_addr", 64'(rom_addr), 64'd15);
         if (k >= 5 && k <= 21) check_eq("rom_mode", 64'(rom_mode.id), 64'(new_id));
         if (k == 22) begin
            check_eq("busy_swap", 64'(busy), 64'd1);
            check_eq("done_early", 64'(done), 64'd0);
            issue_read(4'd3, exp_line(act_valid, act_id, 4'd3));
         end
         if (k == 23) begin
            check_eq("done_pulse", 64'(done), 64'd1);
            check_eq("busy_after", 64'(busy), 64'd0);
            check_eq("label_valid", 64'(label_valid), 64'd1);
            act_id    = new_id;
            act_valid = 1'b1;
            issue_read(4'd3, exp_line(act_valid, act_id, 4'd3));
         end
      end
      @(negedge clock);
      rd_en_tb    = 1'b0;
      last_rom_id = new_id;
      check_eq("done_one_cycle", 64'(done), 64'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_rom_mode"}, 64'(rom_mode), 64'd0);
      check_eq({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
      check_eq({tag, "_rd_data"}, 64'(rd_data), 64'd0);
      check_eq({tag, "_label_valid"}, 64'(label_valid), 64'd0);
      check_eq({tag, "_busy"}, 64'(busy), 64'd0);
      check_eq({tag, "_done"}, 64'(done), 64'd0);
   endtask

   initial begin
      int base;
      reset_n   = 1'b0;
      refresh   = 1'b0;
      rd_addr   = 4'd0;
      videoMode = make_mode(MODE_1080p60);
      repeat (2) @(negedge clock);
      check_zero_outputs("reset");

      // first mode after reset
      reset_n = 1'b1;
      follow_fetch(MODE_1080p60, 1'b0);
      read_all();

      // bouncing mode: no fetch until it holds
      for (int i = 0; i < 9; i++) begin
         videoMode = make_mode((i % 2 == 0) ? MODE_720p60 : MODE_480p60);
         repeat (2) begin
            @(negedge clock);
            check_eq("no_fetch_bounce", 64'(rom_mode.id), 64'(last_rom_id));
         end
      end
      videoMode = make_mode(MODE_480p60);
      follow_fetch(MODE_480p60, 1'b0);
      read_all();

      // abort mid-sweep
      videoMode = make_mode(MODE_720p60);
      for (int k = 1; k <= 12; k++) @(negedge clock);
      check_eq("abort_point_addr", 64'(rom_addr), 64'd7);
      check_eq("abort_point_mode", 64'(rom_mode.id), 64'(MODE_720p60));
      videoMode   = make_mode(MODE_VGA);
      last_rom_id = MODE_720p60;
      follow_fetch(MODE_VGA, 1'b0);
      read_all();

      // refresh in IDLE, plus an ignored refresh during FETCH
      base    = done_cnt;
      refresh = 1'b1;
      follow_fetch(MODE_VGA, 1'b1);
      repeat (10) @(negedge clock);
      check_eq("refresh_done_count", 64'(done_cnt - base), 64'd1);
      read_all();

      // reset in the middle of a sweep
      videoMode = make_mode(MODE_1080p60);
      for (int k = 1; k <= 15; k++) @(negedge clock);
      check_eq("reset_point_addr", 64'(rom_addr), 64'd10);
      reset_n = 1'b0;
      #1;
      check_zero_outputs("midreset");
      act_valid   = 1'b0;
      last_rom_id = 4'd0;
      @(negedge clock);
      reset_n = 1'b1;
      follow_fetch(MODE_1080p60, 1'b0);
      read_all();

      check_eq("rd_queue_drained", 64'(rd_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/resolution_fetch_ctrl.md
# resolution_fetch_ctrl

Sequencer for the resolution-text character ROM. It watches the active video mode and waits for that mode to settle. It then sweeps all 16 ROM lines for the new mode into a shadow bank and atomically swaps that bank into an active bank, which the OSD renderer reads at its own pace. It sits between mode detection and the OSD text renderer, so that the ROM never sees a mode change in the middle of a sweep and the renderer never sees a half-updated resolution label.

## Interface
Parameters:
- SETTLE_CYCLES, 4: consecutive cycles `videoMode.id` must hold a new value before a fetch starts (min 1).
- LINES, 16: ROM lines per mode. Fixed; matches the 4-bit ROM address.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- videoMode  in  VideoMode  current mode; only `.id` is used.
- refresh  in  1  one-cycle strobe that forces a re-fetch of the current mode.
- rom_mode  out  VideoMode  mode presented to the ROM; held stable for a whole sweep.
- rom_addr  out  4  ROM line address.
- rom_q  in  `RESLINE_SIZE  ROM data; valid 1 cycle after `rom_addr`/`rom_mode`.
- rd_addr  in  4  renderer line select.
- rd_data  out  `RESLINE_SIZE  active-bank line; registered, 1-cycle latency.
- label_valid  out  1  high once the first swap has completed.
- busy  out  1  high in SETTLE, FETCH and SWAP.
- done  out  1  one-cycle pulse in the cycle after a swap.

## Operation
- Reset values:
  - State is IDLE.
  - `rom_mode` is all-zero and `rom_addr` is 0.
  - `rd_data`, `label_valid`, `busy` and `done` are 0.
  - Both banks are 0 and the active-bank pointer is 0.
  - The `mode_id_q` register resets to all ones, so the first real mode registers as a change.
- `mode_id_q` registers `videoMode.id` every cycle.
- A change is flagged when `videoMode.id != mode_id_q`.
- States:
  - IDLE:
    - On a change or on `refresh`, go to SETTLE and clear `settle_cnt`.
  - SETTLE:
    - `settle_cnt` increments each cycle no change is flagged; any change clears it.
    - When `settle_cnt == SETTLE_CYCLES-1` with no change, latch `rom_mode <= videoMode`, set `rom_addr <= 0` and go to FETCH.
  - FETCH:
    - `rom_addr` increments each cycle from 0 to 15.
    - Each `rom_q` is written to shadow[`rom_addr` of the previous cycle], starting 1 cycle after address 0 is issued.
    - After issuing address 15, `rom_addr` holds at 15 for one capture cycle. Line 15 is written in that cycle, then the state goes to SWAP.
  - SWAP:
    - Flip the active-bank pointer, set `label_valid <= 1` and return to IDLE.
    - `done` pulses in the following cycle.
- Abort:
  - A change flagged in FETCH returns the state to SETTLE with the counter cleared.
  - The shadow bank is discarded and the active bank is untouched.
  - If an abort coincides with the line-15 capture, the abort wins and no swap happens.
- `refresh` in SETTLE, FETCH or SWAP is ignored. It is not queued.
- Reads:
  - Reads always come from the active bank.
  - A read issued in the SWAP cycle returns the old bank.
  - A read issued in the following cycle returns the new bank.
- Asserting reset mid-operation returns every output to its reset value immediately. `label_valid` drops to 0.

## Timing
- Change-to-FETCH entry: SETTLE_CYCLES + 1 cycles. This is 1 cycle of change detection plus the settle count.
- FETCH is 17 cycles: 16 address issues plus 1 trailing capture.
- SWAP is 1 cycle, and `done` follows in the next cycle.
- Total with the default parameter: a stable change at cycle 0 gives `done` at cycle 24.
- `rom_mode` never changes while in FETCH.
- `rd_data` latency is always exactly 1 cycle, independent of controller state.

## Structure
- The shared package or defines holds:
  - the existing `VideoMode` typedef, `MODE_*` ids and `RESLINE_SIZE`;
  - a new `ResFetchState` enum {IDLE, SETTLE, FETCH, SWAP}.
- One sub-module, `resline_bank`, holds the two banks of 16 x `RESLINE_SIZE`:
  - inputs: a write port (bank select, address, data, enable) and a read port (bank select, address) with a registered output;
  - the banks are inferable as registers or distributed RAM.
- The controller FSM, settle counter and address counter live in the top module.

## Test plan
- Reset, then hold `videoMode.id=MODE_1080p60` steady:
  - `rom_addr` sweeps 0..15;
  - `done` is high at cycle 24;
  - `label_valid=1`;
  - `rd_addr` 0..15 return exactly the ROM lines for 1080p60.
- Toggle `id` between 720p60 and 480p60 every 2 cycles for 20 cycles, then hold 480p60:
  - no FETCH occurs until 4 stable cycles have passed;
  - the final label matches 480p60.
- During FETCH at `rom_addr=7`, change `id` to MODE_VGA:
  - the state returns to SETTLE;
  - the active bank still returns the old labels;
  - the restart sweeps 0..15 with `rom_mode=VGA`;
  - after the swap, reads return the VGA lines.
- Pulse `refresh` in IDLE with an unchanged mode:
  - a full sweep runs and `done` pulses;
  - the contents are identical.
  - A second `refresh` pulsed during FETCH has no effect, and there is exactly one `done`.
- Issue `rd_addr=3` in the SWAP cycle, then again in the next cycle:
  - the first read returns old line 3;
  - the second returns new line 3.
- Assert `reset_n=0` at `rom_addr=10`:
  - all outputs are 0 immediately;
  - after release with a steady mode, a full fetch completes from address 0.
